trellis_table_loader: RTL and testbench
=======================================

Name: trellis_table_loader

Overview:
- Configuration sequencer for the Viterbi decoder's trellis table memory (Next State Table and Output Table).
- Takes n generator polynomials for a (k, m, n) convolutional code and computes every (state, input) entry.
- Writes the entries into the table memory one per cycle through its load/state_address/input_address/next_state_data/output_data write port.
- Start/busy/done handshake toward the top-level decoder controller; a hold input lets the memory port be shared.

Parameters:
- k, 1, input bits per trellis step (table column address width).
- m, 3, total shift-register bits; state width is m-k.
- n, 2, output bits per step (number of generator polynomials).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- start  input  1  one-cycle request to (re)build the tables; sampled only in IDLE.
- hold  input  1  while high in WRITE, sequencing freezes and load is 0.
- gen_poly  input  n*m  generators; generator i = gen_poly[(n-i)*m-1 -: m], MSB aligned to newest input bit.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse after the last entry is written.
- load  output  1  memory write strobe.
- state_address  output  [0:m-k-1]  table row.
- input_address  output  [0:k-1]  table column.
- next_state_data  output  [0:m-k-1]  next state to write.
- output_data  output  [0:n-1]  code output to write; bit 0 comes from generator 0.

Behaviour:
- Reset values: busy=0, done=0, load=0, all address and data outputs 0, FSM=IDLE, counters 0.
- Reset has priority over every other input. Reset mid-WRITE abandons the sequence (no done pulse) and the memory is left partially written.
- The generator latch is captured on start acceptance. gen_poly changes while busy have no effect.
- FSM states:
  - IDLE: start=1 -> latch gen_poly, clear counters, go to WRITE.
  - WRITE: one entry per cycle unless hold=1. Advance after the last entry -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- start while busy or in DONE is ignored.
- Entry computation for row s and column u:
  - R[0:m-1] = {u, s}.
  - next_state = R[0:m-k-1], i.e. {u, s} with the oldest k bits dropped.
  - output bit i = XOR-reduce(R & G_i).
- Order: state outer, input inner: (s=0,u=0), (0,1), ..., (0,2^k-1), (1,0), ..., (2^(m-k)-1, 2^k-1). Total 2^m entries; counters wrap to 0 on completion.
- All write-port outputs are registered. Start sampled at edge t gives the first load=1 at cycle t+1.
- With no hold, the last entry is at cycle t+2^m, done=1 at cycle t+2^m+1, and busy is high for cycles t+1..t+2^m.
- hold=1 in a WRITE cycle:
  - load=0 and the counter is frozen.
  - The address/data outputs keep the pending entry.
  - Writing resumes with that same entry when hold falls; no entry is skipped or duplicated.
- load is never 1 outside WRITE.

Decomposition:
- Shared package viterbi_pkg:
  - loader FSM state enum (IDLE, WRITE, DONE).
  - a parity function (XOR-reduce of an m-bit vector).
  - STATE_W=m-k and ENTRIES=2^m constants derived from the decoder's k, m, n.
- One combinational sub-module, trellis_entry_gen (inputs: s, u, latched generators; outputs: next_state, output_data). The verification bench reuses it as its reference model.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, start=0 -> all outputs 0, load never 1, busy=0 for 20 cycles.
- Full build, k=1, m=3, n=2, gen_poly=6'b111_101, start at cycle 0:
  - load high cycles 1-8.
  - Entries include (s=00,u=1)->ns=10, out=11; (01,0)->00, 11; (10,0)->01, 10; (11,1)->11, 10.
  - done pulse at cycle 9, busy 1-8.
- Hold: same build with hold=1 in cycles 3-5 -> load=0 and outputs frozen on entry (s=01,u=0) during 3-5. All 8 entries written exactly once; done at cycle 12.
- Reset mid-operation: reset at cycle 4 -> next cycle load=0, busy=0, no done. A new start then rebuilds from (0,0) with 8 loads.
- Ignored start and gen_poly change: start pulses and gen_poly=6'b000_000 during busy -> sequence unchanged, outputs match gen 111/101, exactly one done.
- Back-to-back: start in the cycle after done -> second full 8-entry sequence. In the DONE cycle start is ignored.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared Viterbi decoder definitions: code geometry, loader FSM states and parity helper.
package viterbi_pkg;

    localparam int unsigned K          = 1;
    localparam int unsigned M          = 3;
    localparam int unsigned N          = 2;
    localparam int unsigned STATE_W    = M - K;
    localparam int unsigned ENTRIES    = 2 ** M;
    localparam int unsigned PARITY_MAX = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } loader_state_t;

    function automatic logic parity(input logic [PARITY_MAX-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/trellis_entry_gen.sv
// Combinational trellis entry: next state and code output for row s, column u.
module trellis_entry_gen
    import viterbi_pkg::*;
#(
    parameter int unsigned k = K,
    parameter int unsigned m = M,
    parameter int unsigned n = N
) (
    input  logic [m-k-1:0] s,
    input  logic [k-1:0]   u,
    input  logic [n*m-1:0] gens,
    output logic [m-k-1:0] next_state,
    output logic [0:n-1]   output_data
);

    // r[m-1] is the newest input bit, lining up with each generator's MSB
    logic [m-1:0] r;

    assign r          = {u, s};
    assign next_state = r[m-1:k];

    always_comb begin
        output_data = '0;
        for (int unsigned i = 0; i < n; i++) begin
            output_data[i] = parity(PARITY_MAX'(r & gens[(n-i)*m-1 -: m]));
        end
    end

endmodule

// File: rtl/trellis_table_loader.sv
// Sequencer that fills the next-state and output tables one entry per cycle.
module trellis_table_loader
    import viterbi_pkg::*;
#(
    parameter int unsigned k = K,
    parameter int unsigned m = M,
    parameter int unsigned n = N
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             hold,
    input  logic [n*m-1:0]   gen_poly,
    output logic             busy,
    output logic             done,
    output logic             load,
    output logic [0:m-k-1]   state_address,
    output logic [0:k-1]     input_address,
    output logic [0:m-k-1]   next_state_data,
    output logic [0:n-1]     output_data
);

    localparam int unsigned STW = m - k;

    loader_state_t  state_q, state_d;
    logic [m-1:0]   cnt_q, cnt_d;
    logic [n*m-1:0] gen_q, gen_d;
    logic           load_d, busy_d, done_d;
    logic [STW-1:0] ns_d;
    logic [0:n-1]   out_d;

    // Entry generator looks at the next counter so the write port registers
    // always present the entry that is pending in the following cycle.
    trellis_entry_gen #(
        .k(k),
        .m(m),
        .n(n)
    ) u_entry (
        .s          (cnt_d[m-1:k]),
        .u          (cnt_d[k-1:0]),
        .gens       (gen_d),
        .next_state (ns_d),
        .output_data(out_d)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gen_d   = gen_q;
        load_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                    gen_d   = gen_poly;
                    load_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            WRITE: begin
                busy_d = 1'b1;
                load_d = ~hold;
                // load_q marks the presented entry as written at this edge
                if (load) begin
                    if (cnt_q == '1) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        load_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + m'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            gen_q           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            load            <= 1'b0;
            state_address   <= '0;
            input_address   <= '0;
            next_state_data <= '0;
            output_data     <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            gen_q           <= gen_d;
            busy            <= busy_d;
            done            <= done_d;
            load            <= load_d;
            state_address   <= cnt_d[m-1:k];
            input_address   <= cnt_d[k-1:0];
            next_state_data <= ns_d;
            output_data     <= out_d;
        end
    end

endmodule

// File: tb/tb_trellis_table_loader.sv
// Self-checking bench for trellis_table_loader with a bit-level trellis reference model.
module tb_trellis_table_loader;

    localparam int K   = 1;
    localparam int M   = 3;
    localparam int N   = 2;
    localparam int STW = M - K;
    localparam int ENT = 1 << M;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             hold;
    logic [N*M-1:0]   gen_poly;
    logic             busy;
    logic             done;
    logic             load;
    logic [0:STW-1]   state_address;
    logic [0:K-1]     input_address;
    logic [0:STW-1]   next_state_data;
    logic [0:N-1]     output_data;

    int tests_run    = 0;
    int tests_failed = 0;

    // Hand-derived {next_state, output} table for generators 111 / 101
    logic [STW+N-1:0] ref_tab [ENT] = '{4'b0000, 4'b1011, 4'b0011, 4'b1000,
                                        4'b0110, 4'b1101, 4'b0101, 4'b1110};

    trellis_table_loader #(
        .k(K),
        .m(M),
        .n(N)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .hold           (hold),
        .gen_poly       (gen_poly),
        .busy           (busy),
        .done           (done),
        .load           (load),
        .state_address  (state_address),
        .input_address  (input_address),
        .next_state_data(next_state_data),
        .output_data    (output_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // R = {u, s}; next state drops the oldest k bits; output i = parity(R & G_i)
    function automatic logic [STW+N-1:0] model(input int idx, input logic [N*M-1:0] g);
        bit               r [M];
        logic [STW-1:0]   ns;
        logic [N-1:0]     o;
        int               s;
        int               u;
        bit               p;
        s = idx / (1 << K);
        u = idx % (1 << K);
        for (int j = 0; j < M; j++) begin
            if (j < K) r[j] = ((u >> (K - 1 - j)) & 1) != 0;
            else       r[j] = ((s >> (STW - 1 - (j - K))) & 1) != 0;
        end
        for (int j = 0; j < STW; j++) ns[STW-1-j] = r[j];
        for (int i = 0; i < N; i++) begin
            p = 1'b0;
            for (int j = 0; j < M; j++) p = p ^ (r[j] & g[(N-i)*M-1-j]);
            o[N-1-i] = p;
        end
        return {ns, o};
    endfunction

    // hold_mode: 0 none, 1 hold high in cycles 2-4, 2 random
    task automatic run_build(input string name, input logic [N*M-1:0] gens, input int hold_mode,
                             input bit noise, input bit use_tab, input bit start_in_done,
                             input int exp_done);
        int               c, widx, hold_eff, done_cnt, done_cyc;
        bit               prev_hold, prev_busy, fin;
        logic [STW+N-1:0] e;
        logic [STW-1:0]   o_s, o_ns;
        logic [K-1:0]     o_u;
        logic [N-1:0]     o_out;
        gen_poly = gens;
        hold     = 1'b0;
        start    = 1'b1;
        tick();
        start     = 1'b0;
        c         = 1;
        widx      = 0;
        hold_eff  = 0;
        done_cnt  = 0;
        done_cyc  = -1;
        prev_hold = 1'b0;
        prev_busy = 1'b0;
        fin       = 1'b0;
        while (!fin && c < 80) begin
            o_s   = state_address;
            o_u   = input_address;
            o_ns  = next_state_data;
            o_out = output_data;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
                fin      = 1'b1;
                tests_run++;
                if (busy !== 1'b0 || load !== 1'b0 || widx != ENT) begin
                    tests_failed++;
                    $display("FAIL %s done_state: cycle %0d busy=%b load=%b written=%0d, required busy=0 load=0 written=%0d",
                             name, c, busy, load, widx, ENT);
                end
            end else begin
                tests_run++;
                if (busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s busy: cycle %0d got %b, required 1", name, c, busy);
                end
                tests_run++;
                if (widx >= ENT) begin
                    tests_failed++;
                    $display("FAIL %s overrun: cycle %0d load=%b after %0d entries, required done", name, c, load, widx);
                end else begin
                    e = model(widx, gens);
                    if ({o_s, o_u} !== widx[M-1:0] || {o_ns, o_out} !== e) begin
                        tests_failed++;
                        $display("FAIL %s entry: cycle %0d load=%b got s=%b u=%b ns=%b out=%b, required s=%b u=%b ns=%b out=%b",
                                 name, c, load, o_s, o_u, o_ns, o_out, widx[M-1:K], widx[K-1:0], e[STW+N-1:N], e[N-1:0]);
                    end
                    if (use_tab && load === 1'b1) begin
                        tests_run++;
                        if ({o_ns, o_out} !== ref_tab[widx]) begin
                            tests_failed++;
                            $display("FAIL %s table: entry %0d got ns=%b out=%b, required ns=%b out=%b",
                                     name, widx, o_ns, o_out, ref_tab[widx][STW+N-1:N], ref_tab[widx][N-1:0]);
                        end
                    end
                end
                if (prev_hold && prev_busy) begin
                    tests_run++;
                    if (load !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL %s hold_load: cycle %0d got load=%b after hold, required 0", name, c, load);
                    end
                end
            end
            prev_busy = (busy === 1'b1);
            if (fin) begin
                hold     = 1'b0;
                start    = start_in_done;
                gen_poly = gens;
            end else begin
                case (hold_mode)
                    1:       hold = (c >= 2 && c <= 4);
                    2:       hold = ($urandom_range(0, 2) == 0);
                    default: hold = 1'b0;
                endcase
                // a hold in the cycle that writes the final entry costs nothing
                if (hold && !(load === 1'b1 && widx == ENT - 1)) hold_eff++;
                if (load === 1'b1) widx++;
                if (noise) begin
                    start    = ($urandom_range(0, 1) == 1);
                    gen_poly = '0;
                end
                prev_hold = hold;
                tick();
                c++;
            end
        end
        hold     = 1'b0;
        gen_poly = gens;
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++;
            $display("FAIL %s done_count: got %0d done pulses within 80 cycles, required 1", name, done_cnt);
        end
        tests_run++;
        if (done_cyc != ENT + 1 + hold_eff || (exp_done >= 0 && done_cyc != exp_done)) begin
            tests_failed++;
            $display("FAIL %s done_cycle: got %0d, required %0d", name, done_cyc,
                     (exp_done >= 0) ? exp_done : ENT + 1 + hold_eff);
        end
        if (start_in_done) begin
            tick();
            start = 1'b0;
            tests_run++;
            if (busy !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s start_in_done: got busy=%b load=%b done=%b, required 0 0 0", name, busy, load, done);
            end
        end else begin
            start = 1'b0;
            repeat (2) begin
                tick();
                tests_run++;
                if (busy !== 1'b0 || load !== 1'b0 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s quiet_after: got busy=%b load=%b done=%b, required 0 0 0", name, busy, load, done);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        gen_poly = 6'b111101;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tests_run++;
            if ({busy, done, load} !== 3'b000 || state_address !== '0 || input_address !== '0 ||
                next_state_data !== '0 || output_data !== '0) begin
                tests_failed++;
                $display("FAIL reset_idle: cycle %0d got busy=%b done=%b load=%b sa=%b ia=%b ns=%b out=%b, required all 0",
                         i, busy, done, load, state_address, input_address, next_state_data, output_data);
            end
            tick();
        end
    endtask

    task automatic test_full_build();
        run_build("full_111_101", 6'b111101, 0, 1'b0, 1'b1, 1'b0, ENT + 1);
        repeat (2) run_build("full_random", 6'($urandom), 0, 1'b0, 1'b0, 1'b0, ENT + 1);
    endtask

    task automatic test_hold();
        run_build("hold_window", 6'b111101, 1, 1'b0, 1'b1, 1'b0, 12);
        repeat (3) run_build("hold_random", 6'($urandom), 2, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        gen_poly = 6'b111101;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({busy, done, load} !== 3'b000 || state_address !== '0 || input_address !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: got busy=%b done=%b load=%b sa=%b ia=%b, required all 0",
                     busy, done, load, state_address, input_address);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            tests_run++;
            if ({busy, done, load} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_mid_quiet: cycle %0d got busy=%b done=%b load=%b, required 0 0 0",
                         i, busy, done, load);
            end
        end
        run_build("after_reset", 6'b111101, 0, 1'b0, 1'b1, 1'b0, ENT + 1);
    endtask

    task automatic test_ignored_start();
        run_build("ignored_start", 6'b111101, 0, 1'b1, 1'b1, 1'b0, ENT + 1);
        run_build("ignored_start_hold", 6'($urandom), 2, 1'b1, 1'b0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_build("b2b_first", 6'b111101, 0, 1'b0, 1'b1, 1'b1, ENT + 1);
        run_build("b2b_second", 6'b110011, 0, 1'b0, 1'b0, 1'b1, ENT + 1);
        run_build("b2b_third", 6'($urandom), 2, 1'b0, 1'b0, 1'b0, -1);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        hold     = 1'b0;
        gen_poly = '0;
        test_reset();
        test_full_build();
        test_hold();
        test_reset_mid();
        test_ignored_start();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
